// File: rtl/fp_divider_seq.sv
// IEEE-754 single-precision sequential divider (restoring), optional radix-4 via DIV_RADIX4_EN.
// Latency: 28 cycles normal (15 with DIV_RADIX4_EN), 1 cycle for special operand pairs.
// Backpressure: Start is ignored while Busy; no queuing, results held until the next Done.
module fp_divider_seq (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic        Sx,
    input  logic        Sy,
    input  logic [7:0]  Ex,
    input  logic [7:0]  Ey,
    input  logic [22:0] Mx,
    input  logic [22:0] My,
    input  logic [1:0]  R_mode,
    output logic        Busy,
    output logic        Done,
    output logic        Sz,
    output logic [7:0]  Ez,
    output logic [23:0] Mz,
    output logic        invalid_flag,
    output logic        overflow_flag,
    output logic        underflow_flag,
    output logic        inexact_flag,
    output logic        zero_flag,
    output logic        div_by_zero_flag
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DIVIDE   = 2'd1;
    localparam logic [1:0] NORM_RND = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

`ifdef DIV_RADIX4_EN
    localparam logic [4:0] ITER_LAST = 5'd12;
`else
    localparam logic [4:0] ITER_LAST = 5'd25;
`endif

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [1:0]  rmode_r;
    logic        sign_r;
    logic [9:0]  exp_r;
    logic [23:0] div_y;
    logic [24:0] rem;
    logic [25:0] q;

    // One restoring step: returns {quotient bit, shifted partial remainder}.
    function automatic logic [25:0] div_step(input logic [24:0] r, input logic [23:0] d);
        logic [25:0] diff;
        diff = {1'b0, r} - {2'b00, d};
        if (!diff[25])
            div_step = {1'b1, diff[24:0] << 1};
        else
            div_step = {1'b0, r << 1};
    endfunction

    logic [24:0] rem_nx;
    logic [25:0] q_nx;

    always_comb begin
        logic [25:0] s1;
`ifdef DIV_RADIX4_EN
        logic [25:0] s2;
        s1     = div_step(rem, div_y);
        s2     = div_step(s1[24:0], div_y);
        rem_nx = s2[24:0];
        q_nx   = {q[23:0], s1[25], s2[25]};
`else
        s1     = div_step(rem, div_y);
        rem_nx = s1[24:0];
        q_nx   = {q[24:0], s1[25]};
`endif
    end

    // Special operand classification on the live inputs, used only at accept.
    logic       x_nan, x_inf, x_zero, y_nan, y_inf, y_zero;
    logic       is_special;
    logic       spc_sign;
    logic [7:0] spc_exp;
    logic [23:0] spc_mant;
    logic       spc_inv, spc_dbz, spc_zero;

    always_comb begin
        x_nan  = (Ex == 8'hFF) && (Mx != 23'd0);
        x_inf  = (Ex == 8'hFF) && (Mx == 23'd0);
        x_zero = (Ex == 8'h00);
        y_nan  = (Ey == 8'hFF) && (My != 23'd0);
        y_inf  = (Ey == 8'hFF) && (My == 23'd0);
        y_zero = (Ey == 8'h00);

        is_special = 1'b1;
        spc_sign   = Sx ^ Sy;
        spc_exp    = 8'h00;
        spc_mant   = 24'h000000;
        spc_inv    = 1'b0;
        spc_dbz    = 1'b0;
        spc_zero   = 1'b0;

        if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
            spc_sign = 1'b0;
            spc_exp  = 8'hFF;
            spc_mant = 24'h400000;
            spc_inv  = 1'b1;
        end else if (x_inf) begin
            spc_exp = 8'hFF;
        end else if (y_zero) begin
            spc_exp = 8'hFF;
            spc_dbz = 1'b1;
        end else if (x_zero || y_inf) begin
            spc_zero = 1'b1;
        end else begin
            is_special = 1'b0;
        end
    end

    // Normalize, round and range-check the finished quotient.
    logic [23:0] mant_pre;
    logic        guard, sticky, round_up;
    logic [24:0] mant_sum;
    logic [9:0]  exp_n, exp_f;
    logic [23:0] mant_f;
    logic        ovf, unf, ovf_to_inf;
    logic [7:0]  res_exp;
    logic [23:0] res_mant;
    logic        res_ovf, res_unf, res_inx, res_zero;

    always_comb begin
        if (q[25]) begin
            mant_pre = q[25:2];
            guard    = q[1];
            sticky   = q[0] | (rem != 25'd0);
        end else begin
            mant_pre = q[24:1];
            guard    = q[0];
            sticky   = (rem != 25'd0);
        end
        exp_n = exp_r - {9'd0, ~q[25]};

        case (rmode_r)
            2'b00:   round_up = guard & (sticky | mant_pre[0]);
            2'b01:   round_up = 1'b0;
            2'b10:   round_up = (guard | sticky) & ~sign_r;
            default: round_up = (guard | sticky) & sign_r;
        endcase

        mant_sum = {1'b0, mant_pre} + {24'd0, round_up};
        exp_f    = exp_n + {9'd0, mant_sum[24]};
        mant_f   = mant_sum[24] ? 24'h800000 : mant_sum[23:0];

        ovf        = $signed(exp_f) > $signed(10'sd254);
        unf        = $signed(exp_f) < $signed(10'sd1);
        ovf_to_inf = (rmode_r == 2'b00) || (rmode_r == 2'b10 && !sign_r) ||
                     (rmode_r == 2'b11 && sign_r);

        res_exp  = exp_f[7:0];
        res_mant = mant_f;
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
        res_inx  = guard | sticky;
        res_zero = 1'b0;
        if (ovf) begin
            res_ovf  = 1'b1;
            res_inx  = 1'b1;
            res_exp  = ovf_to_inf ? 8'hFF : 8'hFE;
            res_mant = ovf_to_inf ? 24'h000000 : 24'hFFFFFF;
        end else if (unf) begin
            res_unf  = 1'b1;
            res_inx  = 1'b1;
            res_zero = 1'b1;
            res_exp  = 8'h00;
            res_mant = 24'h000000;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state            <= IDLE;
            cnt              <= 5'd0;
            rmode_r          <= 2'b00;
            sign_r           <= 1'b0;
            exp_r            <= 10'd0;
            div_y            <= 24'd0;
            rem              <= 25'd0;
            q                <= 26'd0;
            Busy             <= 1'b0;
            Done             <= 1'b0;
            Sz               <= 1'b0;
            Ez               <= 8'd0;
            Mz               <= 24'd0;
            invalid_flag     <= 1'b0;
            overflow_flag    <= 1'b0;
            underflow_flag   <= 1'b0;
            inexact_flag     <= 1'b0;
            zero_flag        <= 1'b0;
            div_by_zero_flag <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        Busy    <= 1'b1;
                        rmode_r <= R_mode;
                        sign_r  <= Sx ^ Sy;
                        if (is_special) begin
                            Done             <= 1'b1;
                            Sz               <= spc_sign;
                            Ez               <= spc_exp;
                            Mz               <= spc_mant;
                            invalid_flag     <= spc_inv;
                            overflow_flag    <= 1'b0;
                            underflow_flag   <= 1'b0;
                            inexact_flag     <= 1'b0;
                            zero_flag        <= spc_zero;
                            div_by_zero_flag <= spc_dbz;
                            state            <= DONE;
                        end else begin
                            div_y <= {1'b1, My};
                            rem   <= {2'b01, Mx};
                            q     <= 26'd0;
                            exp_r <= {2'b00, Ex} - {2'b00, Ey} + 10'd127;
                            cnt   <= ITER_LAST;
                            state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    rem <= rem_nx;
                    q   <= q_nx;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0)
                        state <= NORM_RND;
                end
                NORM_RND: begin
                    Done             <= 1'b1;
                    Sz               <= sign_r;
                    Ez               <= res_exp;
                    Mz               <= res_mant;
                    invalid_flag     <= 1'b0;
                    overflow_flag    <= res_ovf;
                    underflow_flag   <= res_unf;
                    inexact_flag     <= res_inx;
                    zero_flag        <= res_zero;
                    div_by_zero_flag <= 1'b0;
                    state            <= DONE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider_seq.sv
// Directed self-checking bench for fp_divider_seq.
module tb_fp_divider_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        Start = 1'b0;
    logic        Sx = 1'b0, Sy = 1'b0;
    logic [7:0]  Ex = 8'd0, Ey = 8'd0;
    logic [22:0] Mx = 23'd0, My = 23'd0;
    logic [1:0]  R_mode = 2'b00;
    logic        Busy, Done, Sz;
    logic [7:0]  Ez;
    logic [23:0] Mz;
    logic        invalid_flag, overflow_flag, underflow_flag;
    logic        inexact_flag, zero_flag, div_by_zero_flag;
    logic [5:0]  flags;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef DIV_RADIX4_EN
    localparam int NORM_LAT = 15;
`else
    localparam int NORM_LAT = 28;
`endif

    fp_divider_seq dut (
        .CLK(CLK), .RST(RST), .Start(Start),
        .Sx(Sx), .Sy(Sy), .Ex(Ex), .Ey(Ey), .Mx(Mx), .My(My), .R_mode(R_mode),
        .Busy(Busy), .Done(Done), .Sz(Sz), .Ez(Ez), .Mz(Mz),
        .invalid_flag(invalid_flag), .overflow_flag(overflow_flag),
        .underflow_flag(underflow_flag), .inexact_flag(inexact_flag),
        .zero_flag(zero_flag), .div_by_zero_flag(div_by_zero_flag)
    );

    always #5 CLK = ~CLK;

    // {invalid, overflow, underflow, inexact, zero, div_by_zero}
    assign flags = {invalid_flag, overflow_flag, underflow_flag,
                    inexact_flag, zero_flag, div_by_zero_flag};

    // Launch one operation, scramble inputs after accept, return Done latency (-1 on timeout).
    task automatic run_op(input logic sx, input logic [7:0] ex, input logic [22:0] mx,
                          input logic sy, input logic [7:0] ey, input logic [22:0] my,
                          input logic [1:0] rm, output int lat);
        @(negedge CLK);
        Sx = sx; Ex = ex; Mx = mx; Sy = sy; Ey = ey; My = my; R_mode = rm; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        Sx = ~sx; Sy = ~sy; Ex = 8'($urandom); Ey = 8'($urandom);
        Mx = 23'($urandom); My = 23'($urandom); R_mode = 2'($urandom);
        lat = 1;
        while (Done !== 1'b1 && lat < 80) begin
            @(negedge CLK);
            lat++;
        end
        if (Done !== 1'b1) lat = -1;
    endtask

    task automatic test_reset;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        n_tests++; if ({Busy, Done} !== 2'b00) begin n_fail++; $display("FAIL reset busy/done: got %b want 00", {Busy, Done}); end
        n_tests++; if ({Sz, Ez, Mz} !== 33'd0) begin n_fail++; $display("FAIL reset result: got %h want 0", {Sz, Ez, Mz}); end
        n_tests++; if (flags !== 6'b0) begin n_fail++; $display("FAIL reset flags: got %b want 000000", flags); end
        RST = 1'b1;
    endtask

    task automatic test_normal;
        int lat;
        run_op(1'b0, 8'd129, 23'h400000, 1'b0, 8'd128, 23'h0, 2'b00, lat);
        n_tests++; if (lat !== NORM_LAT) begin n_fail++; $display("FAIL 6/2 latency: got %0d want %0d", lat, NORM_LAT); end
        n_tests++; if ({Sz, Ez, Mz} !== {1'b0, 8'd128, 24'hC00000}) begin n_fail++; $display("FAIL 6/2 result: got %b %0d %h want 0 128 c00000", Sz, Ez, Mz); end
        n_tests++; if (flags !== 6'b0) begin n_fail++; $display("FAIL 6/2 flags: got %b want 000000", flags); end
        n_tests++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL 6/2 busy at done: got %b want 1", Busy); end
        @(negedge CLK);
        n_tests++; if ({Done, Busy} !== 2'b00) begin n_fail++; $display("FAIL 6/2 done pulse: got done/busy %b want 00", {Done, Busy}); end
        n_tests++; if ({Ez, Mz} !== {8'd128, 24'hC00000}) begin n_fail++; $display("FAIL 6/2 hold: got %0d %h want 128 c00000", Ez, Mz); end
        run_op(1'b1, 8'd129, 23'h400000, 1'b0, 8'd128, 23'h0, 2'b00, lat);
        n_tests++; if ({Sz, Ez, Mz} !== {1'b1, 8'd128, 24'hC00000}) begin n_fail++; $display("FAIL -6/2 result: got %b %0d %h want 1 128 c00000", Sz, Ez, Mz); end
    endtask

    task automatic test_rounding;
        int lat;
        run_op(1'b0, 8'd127, 23'h0, 1'b0, 8'd128, 23'h400000, 2'b00, lat);
        n_tests++; if ({Ez, Mz} !== {8'd125, 24'hAAAAAB}) begin n_fail++; $display("FAIL 1/3 rne: got %0d %h want 125 aaaaab", Ez, Mz); end
        n_tests++; if (flags !== 6'b000100) begin n_fail++; $display("FAIL 1/3 rne flags: got %b want 000100", flags); end
        run_op(1'b0, 8'd127, 23'h0, 1'b0, 8'd128, 23'h400000, 2'b01, lat);
        n_tests++; if ({Ez, Mz} !== {8'd125, 24'hAAAAAA}) begin n_fail++; $display("FAIL 1/3 rtz: got %0d %h want 125 aaaaaa", Ez, Mz); end
        n_tests++; if (inexact_flag !== 1'b1) begin n_fail++; $display("FAIL 1/3 rtz inexact: got %b want 1", inexact_flag); end
        run_op(1'b0, 8'd127, 23'h0, 1'b0, 8'd128, 23'h400000, 2'b10, lat);
        n_tests++; if (Mz !== 24'hAAAAAB) begin n_fail++; $display("FAIL 1/3 +inf: got %h want aaaaab", Mz); end
        run_op(1'b1, 8'd127, 23'h0, 1'b0, 8'd128, 23'h400000, 2'b10, lat);
        n_tests++; if ({Sz, Mz} !== {1'b1, 24'hAAAAAA}) begin n_fail++; $display("FAIL -1/3 +inf: got %b %h want 1 aaaaaa", Sz, Mz); end
        run_op(1'b1, 8'd127, 23'h0, 1'b0, 8'd128, 23'h400000, 2'b11, lat);
        n_tests++; if ({Sz, Mz} !== {1'b1, 24'hAAAAAB}) begin n_fail++; $display("FAIL -1/3 -inf: got %b %h want 1 aaaaab", Sz, Mz); end
    endtask

    task automatic test_special;
        int lat;
        run_op(1'b0, 8'd127, 23'h0, 1'b0, 8'd0, 23'h0, 2'b00, lat);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL 1/0 latency: got %0d want 1", lat); end
        n_tests++; if ({Ez, Mz, flags} !== {8'd255, 24'h0, 6'b000001}) begin n_fail++; $display("FAIL 1/0: got %0d %h %b want 255 000000 000001", Ez, Mz, flags); end
        run_op(1'b0, 8'd0, 23'h0, 1'b0, 8'd0, 23'h0, 2'b00, lat);
        n_tests++; if ({Ez, Mz, flags} !== {8'd255, 24'h400000, 6'b100000}) begin n_fail++; $display("FAIL 0/0: got %0d %h %b want 255 400000 100000", Ez, Mz, flags); end
        run_op(1'b1, 8'd255, 23'h1, 1'b0, 8'd127, 23'h0, 2'b00, lat);
        n_tests++; if ({Sz, Ez, Mz, flags} !== {1'b0, 8'd255, 24'h400000, 6'b100000}) begin n_fail++; $display("FAIL nan/1: got %b %0d %h %b want 0 255 400000 100000", Sz, Ez, Mz, flags); end
        run_op(1'b1, 8'd255, 23'h0, 1'b0, 8'd128, 23'h0, 2'b00, lat);
        n_tests++; if ({Sz, Ez, Mz, flags} !== {1'b1, 8'd255, 24'h0, 6'b000000}) begin n_fail++; $display("FAIL -inf/2: got %b %0d %h %b want 1 255 000000 000000", Sz, Ez, Mz, flags); end
        run_op(1'b0, 8'd0, 23'h0, 1'b1, 8'd129, 23'h200000, 2'b00, lat);
        n_tests++; if ({Sz, Ez, Mz, flags} !== {1'b1, 8'd0, 24'h0, 6'b000010}) begin n_fail++; $display("FAIL 0/-5: got %b %0d %h %b want 1 0 000000 000010", Sz, Ez, Mz, flags); end
        run_op(1'b0, 8'd0, 23'h123, 1'b0, 8'd127, 23'h0, 2'b00, lat);
        n_tests++; if ({Ez, Mz, flags} !== {8'd0, 24'h0, 6'b000010}) begin n_fail++; $display("FAIL subnormal/1: got %0d %h %b want 0 000000 000010", Ez, Mz, flags); end
        run_op(1'b0, 8'd128, 23'h400000, 1'b0, 8'd255, 23'h0, 2'b00, lat);
        n_tests++; if ({Ez, Mz, flags} !== {8'd0, 24'h0, 6'b000010}) begin n_fail++; $display("FAIL 3/inf: got %0d %h %b want 0 000000 000010", Ez, Mz, flags); end
    endtask

    task automatic test_range;
        int lat;
        run_op(1'b0, 8'd254, 23'h0, 1'b0, 8'd1, 23'h0, 2'b00, lat);
        n_tests++; if ({Ez, Mz, flags} !== {8'd255, 24'h0, 6'b010100}) begin n_fail++; $display("FAIL ovf rne: got %0d %h %b want 255 000000 010100", Ez, Mz, flags); end
        run_op(1'b0, 8'd254, 23'h0, 1'b0, 8'd1, 23'h0, 2'b10, lat);
        n_tests++; if ({Ez, Mz} !== {8'd255, 24'h0}) begin n_fail++; $display("FAIL ovf +inf: got %0d %h want 255 000000", Ez, Mz); end
        run_op(1'b0, 8'd1, 23'h0, 1'b0, 8'd200, 23'h0, 2'b00, lat);
        n_tests++; if ({Ez, Mz, flags} !== {8'd0, 24'h0, 6'b001110}) begin n_fail++; $display("FAIL unf: got %0d %h %b want 0 000000 001110", Ez, Mz, flags); end
        run_op(1'b0, 8'd254, 23'h0, 1'b0, 8'd1, 23'h0, 2'b01, lat);
        n_tests++; if ({Ez, Mz, flags} !== {8'd254, 24'hFFFFFF, 6'b010100}) begin n_fail++; $display("FAIL ovf rtz: got %0d %h %b want 254 ffffff 010100", Ez, Mz, flags); end
    endtask

    task automatic test_abort;
        int dones;
        @(negedge CLK);
        Sx = 1'b0; Ex = 8'd129; Mx = 23'h400000; Sy = 1'b0; Ey = 8'd128; My = 23'h0; R_mode = 2'b00;
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        repeat (9) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        n_tests++; if ({Busy, Done} !== 2'b00) begin n_fail++; $display("FAIL abort busy/done: got %b want 00", {Busy, Done}); end
        n_tests++; if ({Sz, Ez, Mz, flags} !== 39'd0) begin n_fail++; $display("FAIL abort outputs: got %h want 0", {Sz, Ez, Mz, flags}); end
        RST = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge CLK);
            if (Done === 1'b1) dones++;
        end
        n_tests++; if (dones !== 0) begin n_fail++; $display("FAIL abort no done: got %0d want 0", dones); end
    endtask

    task automatic test_back_to_back;
        int dones;
        @(negedge CLK);
        Sx = 1'b0; Ex = 8'd129; Mx = 23'h400000; Sy = 1'b0; Ey = 8'd128; My = 23'h0; R_mode = 2'b00;
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        dones = (Done === 1'b1) ? 1 : 0;
        repeat (4) @(negedge CLK);
        Ex = 8'd127; Mx = 23'h0; Ey = 8'd0; My = 23'h0; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        repeat (70) begin
            @(negedge CLK);
            if (Done === 1'b1) dones++;
        end
        n_tests++; if (dones !== 1) begin n_fail++; $display("FAIL busy start dones: got %0d want 1", dones); end
        n_tests++; if ({Ez, Mz, flags} !== {8'd128, 24'hC00000, 6'b0}) begin n_fail++; $display("FAIL busy start result: got %0d %h %b want 128 c00000 000000", Ez, Mz, flags); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_rounding();
        test_special();
        test_range();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_divider_seq.md
FP_DIVIDER_SEQ -- requirements
Module: fp_divider_seq

Interface
REQ-001 SHALL have port CLK, input, 1, single clock; all state changes on the rising edge.
REQ-002 SHALL have port RST, input, 1, reset that is synchronous and active-low.
REQ-003 SHALL have port Start, input, 1, request pulse, sampled only in IDLE.
REQ-004 SHALL have ports Sx,Sy (input, 1), Ex,Ey (input, 8) and Mx,My (input, 23), the dividend x and divisor y in IEEE-754 single-precision fields.
REQ-005 SHALL have port R_mode, input, 2, rounding mode: 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf.
REQ-006 SHALL have port Busy, output, 1, high from the cycle after Start is accepted until Done.
REQ-007 SHALL have port Done, output, 1, one-cycle pulse; result and flags are valid in that cycle.
REQ-008 SHALL have ports Sz (output, 1), Ez (output, 8) and Mz (output, 24), the registered quotient; Mz[23] is the hidden bit, 1 for finite nonzero results and 0 otherwise.
REQ-009 SHALL have outputs invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag and div_by_zero_flag, 1 bit each, registered and valid with Done.

Function
REQ-010 SHALL implement FSM states IDLE, DIVIDE, NORM_RND and DONE: IDLE->DIVIDE on Start with a normal operand pair; IDLE->DONE on Start with a special pair; DIVIDE->NORM_RND when the iteration count is exhausted; NORM_RND->DONE; DONE->IDLE unconditionally.
REQ-011 SHALL capture all operand inputs and R_mode on the accepting edge; later input changes SHALL not affect the operation.
REQ-012 SHALL ignore Start while Busy=1, with no queuing.
REQ-013 SHALL treat Ex=0 as zero, flushing subnormal inputs.
REQ-014 SHALL set Sz=Sx^Sy for every result, including zero and inf; NaN results SHALL have Sz=0.
REQ-015 SHALL produce quotient q[25:0] from 1.Mx/1.My by restoring division, one bit per DIVIDE cycle, giving 26 DIVIDE cycles.
REQ-016 SHALL normalize: if q[25]=1, mantissa=q[25:2], guard=q[1], sticky=q[0]|(remainder!=0); otherwise mantissa=q[24:1], guard=q[0], sticky=(remainder!=0), and the exponent is decremented by 1.
REQ-017 SHALL compute the exponent in 10-bit signed arithmetic as Ex-Ey+127, adjusted by the normalize decrement, plus 1 on rounding carry-out (mantissa then becomes 0x800000).
REQ-018 SHALL round per R_mode using guard/sticky, and set inexact_flag=guard|sticky.
REQ-019 SHALL handle exponent overflow (>=255) by setting overflow_flag=1 and inexact_flag=1, then returning inf (Ez=255, Mz=0) for RNE and for a directed mode rounding away from zero; otherwise return max finite (Ez=254, Mz=0xFFFFFF).
REQ-020 SHALL handle exponent underflow (<=0) by returning zero (Ez=0, Mz=0) with underflow_flag=1, inexact_flag=1 and zero_flag=1.
REQ-021 SHALL map special pairs as follows: NaN operand, 0/0 or inf/inf gives invalid_flag=1, Ez=255, Mz=0x400000; finite nonzero/0 gives inf with div_by_zero_flag=1; inf/finite gives inf; 0/nonzero or finite/inf gives zero with zero_flag=1.
REQ-022 SHALL have latency, from the accepting edge to Done high, of 28 cycles for normal pairs and 1 cycle for special pairs.
REQ-023 SHALL hold outputs stable after Done until the next accepted operation's Done.

Reset
REQ-024 SHALL, when RST=0 on a rising edge, force IDLE, Busy=0, Done=0, Sz=0, Ez=0, Mz=0 and all flags to 0; this takes priority over Start.
REQ-025 SHALL abort an operation in progress on reset, with no Done for the aborted operation.

Configuration
REQ-026 SHALL provide macro DIV_RADIX4_EN; when defined, DIVIDE SHALL retire 2 quotient bits per cycle (13 DIVIDE cycles, normal latency 15) with bit-identical results; when undefined, DIVIDE SHALL retire 1 bit per cycle (latency 28).

Verification
REQ-027 SHALL cover 6.0/2.0 (Ex=129, Mx=0x400000, Ey=128, My=0) -> Ez=128, Mz=0xC00000, all flags 0, Done at cycle 28 (15 with DIV_RADIX4_EN).
REQ-028 SHALL cover 1.0/3.0 (Ex=127, Mx=0, Ey=128, My=0x400000) -> Ez=125; R_mode=00 gives Mz=0xAAAAAB, R_mode=01 gives Mz=0xAAAAAA; inexact_flag=1 in both.
REQ-029 SHALL cover 1.0/0.0 -> Ez=255, Mz=0, div_by_zero_flag=1, Done 1 cycle after Start; and 0/0 -> invalid_flag=1, Ez=255, Mz=0x400000.
REQ-030 SHALL cover Ex=254, Mx=0 over Ey=1, My=0, Sx=Sy=0 -> R_mode=00 gives Ez=255, Mz=0, overflow_flag=1, inexact_flag=1; R_mode=01 gives Ez=254, Mz=0xFFFFFF.
REQ-031 SHALL cover Ex=1 over Ey=200 -> Ez=0, Mz=0, underflow_flag=1, zero_flag=1, inexact_flag=1.
REQ-032 SHALL cover RST=0 at cycle 10 of a division -> next cycle Busy=0 and outputs 0, no Done; Start pulsed while Busy=1 -> ignored, only one Done.
